// File: rtl/alu_sequencer.sv
// Command-driven sequencer for a combinational ALU: holds an accumulator, runs an
// operation a programmable number of times against it, and returns result plus flags.
module alu_sequencer #(
    parameter int W = 4,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         CMD_VALID,
    output logic         CMD_READY,
    input  logic         CMD_LOAD,
    input  logic [1:0]   CMD_OP,
    input  logic [W-1:0] CMD_OPERAND,
    input  logic [R-1:0] CMD_REPEAT,
    output logic [W-1:0] ALU_A,
    output logic [W-1:0] ALU_B,
    output logic [1:0]   ALU_CTRL,
    input  logic [W-1:0] ALU_OUT,
    input  logic         ALU_CO,
    input  logic         ALU_OVF,
    input  logic         ALU_N,
    input  logic         ALU_Z,
    output logic         RES_VALID,
    input  logic         RES_READY,
    output logic [W-1:0] RES_DATA,
    output logic [3:0]   RES_FLAGS
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state_reg;
    logic [W-1:0]   acc_reg;
    logic [W-1:0]   operand_reg;
    logic [1:0]     op_reg;
    logic [R-1:0]   cnt_reg;
    logic           sticky_co_reg;
    logic           sticky_ovf_reg;
    logic           cmd_ready_reg;
    logic [W-1:0]   alu_a_reg;
    logic [W-1:0]   alu_b_reg;
    logic [1:0]     alu_ctrl_reg;
    logic           res_valid_reg;
    logic [W-1:0]   res_data_reg;
    logic [3:0]     res_flags_reg;

    assign CMD_READY = cmd_ready_reg;
    assign ALU_A     = alu_a_reg;
    assign ALU_B     = alu_b_reg;
    assign ALU_CTRL  = alu_ctrl_reg;
    assign RES_VALID = res_valid_reg;
    assign RES_DATA  = res_data_reg;
    assign RES_FLAGS = res_flags_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            operand_reg    <= '0;
            op_reg         <= 2'b00;
            cnt_reg        <= '0;
            sticky_co_reg  <= 1'b0;
            sticky_ovf_reg <= 1'b0;
            cmd_ready_reg  <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= 2'b00;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_flags_reg  <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    alu_a_reg    <= acc_reg;
                    alu_b_reg    <= '0;
                    alu_ctrl_reg <= 2'b00;
                    // Acceptance uses the registered ready, so the first IDLE cycle only raises it.
                    if (CMD_VALID && cmd_ready_reg) begin
                        cmd_ready_reg <= 1'b0;
                        if (CMD_LOAD) begin
                            acc_reg       <= CMD_OPERAND;
                            alu_a_reg     <= CMD_OPERAND;
                            res_data_reg  <= CMD_OPERAND;
                            res_flags_reg <= {2'b00, CMD_OPERAND[W-1], (CMD_OPERAND == '0)};
                            res_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            op_reg         <= CMD_OP;
                            operand_reg    <= CMD_OPERAND;
                            cnt_reg        <= (CMD_REPEAT == '0) ? R'(1) : CMD_REPEAT;
                            sticky_co_reg  <= 1'b0;
                            sticky_ovf_reg <= 1'b0;
                            alu_b_reg      <= CMD_OPERAND;
                            alu_ctrl_reg   <= CMD_OP;
                            state_reg      <= EXEC;
                        end
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end

                EXEC: begin
                    acc_reg        <= ALU_OUT;
                    alu_a_reg      <= ALU_OUT;
                    sticky_co_reg  <= sticky_co_reg | ALU_CO;
                    sticky_ovf_reg <= sticky_ovf_reg | ALU_OVF;
                    cnt_reg        <= cnt_reg - R'(1);
                    if (cnt_reg == R'(1)) begin
                        // Carry/overflow accumulate across iterations; N/Z reflect only the last one.
                        res_data_reg  <= ALU_OUT;
                        res_flags_reg <= {sticky_co_reg | ALU_CO, sticky_ovf_reg | ALU_OVF,
                                          ALU_N, ALU_Z};
                        res_valid_reg <= 1'b1;
                        alu_b_reg     <= '0;
                        alu_ctrl_reg  <= 2'b00;
                        state_reg     <= DONE;
                    end else begin
                        alu_b_reg    <= operand_reg;
                        alu_ctrl_reg <= op_reg;
                    end
                end

                DONE: begin
                    if (RES_READY) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven initiator for the team's combinational ALU (W-bit operands, 2-bit control, OUT/CO/OVF/N/Z).
- Holds a W-bit accumulator and accepts commands over a valid/ready handshake.
- Drives the ALU with accumulator and operand for a programmable number of iterations, then returns the result and flags over a second valid/ready handshake.
- Sits between a command source (switch/FSM front end) and one ALU instance.

Parameters:
- W, 4, datapath width; must match the attached ALU.
- R, 4, width of the CMD_REPEAT field.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  sequencer can accept a command.
- CMD_LOAD  input  1  1 = load accumulator with CMD_OPERAND; no ALU operation.
- CMD_OP  input  2  ALU control code used for every iteration.
- CMD_OPERAND  input  W  B operand, or load value.
- CMD_REPEAT  input  R  iteration count; 0 is treated as 1.
- ALU_A  output  W  to ALU DATA_A.
- ALU_B  output  W  to ALU DATA_B.
- ALU_CTRL  output  2  to ALU control.
- ALU_OUT  input  W  from ALU OUT.
- ALU_CO, ALU_OVF, ALU_N, ALU_Z  input  1 each  from the ALU flags.
- RES_VALID  output  1  result available.
- RES_READY  input  1  consumer takes the result.
- RES_DATA  output  W  final accumulator value.
- RES_FLAGS  output  4  {CO, OVF, N, Z}.

Behaviour:
- ALU encoding used throughout: 2'b10 = A+B, 2'b11 = A−B, 2'b00 = AND, 2'b01 = OR. The ALU is purely combinational, so its result is sampled in the same cycle the operands are driven.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state = IDLE; accumulator, count, operand and op registers = 0.
  - ALU_A = ALU_B = 0, ALU_CTRL = 2'b00.
  - CMD_READY = 0 while reset is high; RES_VALID = 0, RES_DATA = 0, RES_FLAGS = 0.
  - Any in-flight command is discarded.
- All outputs are registered. States are IDLE, EXEC, DONE.
- IDLE:
  - CMD_READY = 1; ALU_A = acc, ALU_B = 0, ALU_CTRL = 2'b00.
  - Accept when CMD_VALID && CMD_READY at a rising edge.
  - LOAD command: acc <= CMD_OPERAND. Go to DONE with RES_DATA = operand, CO = OVF = 0, N = operand[W−1], Z = (operand == 0).
  - Otherwise: latch op and operand; cnt <= max(CMD_REPEAT, 1); clear sticky CO/OVF; ALU_A <= acc, ALU_B <= operand, ALU_CTRL <= op; go to EXEC.
- EXEC (one iteration per cycle):
  - At each edge: acc <= ALU_OUT; sticky CO |= ALU_CO; sticky OVF |= ALU_OVF; cnt <= cnt − 1; ALU_A <= ALU_OUT.
  - When cnt == 1: go to DONE with RES_DATA = ALU_OUT and RES_FLAGS = {stickyCO | ALU_CO, stickyOVF | ALU_OVF, ALU_N, ALU_Z}. N and Z come from the final iteration only.
  - CMD_READY = 0 throughout.
- Arithmetic is modulo 2^W; wrap-around is not an error and is reported only through the flags.
- DONE:
  - RES_VALID = 1; RES_DATA and RES_FLAGS held stable until RES_VALID && RES_READY.
  - On handshake: RES_VALID <= 0, return to IDLE. CMD_READY rises the cycle after, so there is no same-cycle accept.
  - CMD_VALID is ignored in DONE.
- Latency from command accept edge to RES_VALID high:
  - LOAD: 1 cycle.
  - ALU command: max(REPEAT, 1) + 1 cycles.
- The accumulator persists across commands and is cleared only by reset.

Test Plan:
- Reset mid-test with random inputs → all outputs 0, CMD_READY = 0; after release, CMD_READY = 1 on the first edge, ALU_CTRL = 00.
- LOAD 4'h5 → RES_VALID 1 cycle after accept, RES_DATA = 5, RES_FLAGS = 4'b0000; acc = 5.
- After LOAD 5: ADD (10) operand 3, REPEAT 3 → ALU_A sequence 5, 8, 11; RES_VALID 4 cycles after accept; RES_DATA = 4'hE, flags {CO=0, OVF=1 sticky from 5+3, N=1, Z=0}.
- LOAD 1, then SUB (11) operand 1, REPEAT 2 → RES_DATA = 4'hF, N = 1, Z = 0. Also REPEAT 0 with operand 1 after LOAD 1 → single iteration, RES_DATA = 0, Z = 1.
- Backpressure: hold RES_READY = 0 for 5 cycles with CMD_VALID = 1 → RES_VALID stays 1, RES_DATA/RES_FLAGS stable, no command accepted; RES_READY = 1 → RES_VALID drops next edge, CMD_READY = 1 one cycle later.
- Assert reset during the 3rd iteration of ADD 1 REPEAT 8 → outputs clear asynchronously. Then ADD 2 REPEAT 1 → RES_DATA = 2, flags 0000.
